// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared constants and state encoding for the Montgomery multiplier
package rsa_pkg;

    // Default operand/modulus width in bits.
    localparam int WIDTH = 8;

    // Start-sampling edge to done: WIDTH RUN steps, one CORR, one DONE.
    localparam int LATENCY = WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mmm_engine.sv
// rtl/mmm_engine.sv - bit-serial Montgomery multiplier, R = A*B*2^-WIDTH mod N
module mmm_engine #(
    parameter int WIDTH = rsa_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             n_err
);

    import rsa_pkg::*;

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Two guard bits: acc < 2N before a step, and acc + B + N must not wrap.
    localparam int AW = WIDTH + 2;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             n_err_q, n_err_d;

    logic [AW-1:0]    b_ext;
    logic [AW-1:0]    n_ext;
    logic [AW-1:0]    step_sum;
    logic [AW-1:0]    step_odd;
    logic [AW-1:0]    step_next;
    logic [AW-1:0]    corr_val;
    logic             corr_ge;
    logic             accept;

    // Datapath: one Montgomery step (add a_i*B, make even with N, halve) and the final conditional subtract.
    always_comb begin
        b_ext     = {2'b00, b_q};
        n_ext     = {2'b00, n_q};
        step_sum  = acc_q + (a_q[idx_q] ? b_ext : '0);
        step_odd  = step_sum + (step_sum[0] ? n_ext : '0);
        step_next = step_odd >> 1;
        corr_ge   = (acc_q >= n_ext);
        corr_val  = corr_ge ? (acc_q - n_ext) : acc_q;
    end

    // A new job may be loaded from IDLE or from DONE; clr always wins over start.
    always_comb begin
        accept = 1'b0;
        if (!clr && start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            accept = 1'b1;
        end
    end

    // Next-state and register update logic; every register holds by default.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        r_d     = r_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        n_err_d = n_err_q;

        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Loading is handled uniformly below for IDLE and DONE.
                end
                ST_RUN: begin
                    acc_d = step_next;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CORR;
                    end
                end
                ST_CORR: begin
                    r_d     = corr_val[WIDTH-1:0];
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (accept) begin
            state_d = ST_RUN;
            a_d     = a;
            b_d     = b;
            n_d     = n;
            acc_d   = '0;
            idx_d   = '0;
            n_err_d = ~n[0];
        end
    end

    // State registers: reset dominates everything, en gates all updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            n_err_q <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            n_err_q <= n_err_d;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy  = (state_q == ST_RUN) || (state_q == ST_CORR);
        done  = (state_q == ST_DONE);
        r     = r_q;
        n_err = n_err_q;
    end

endmodule

// File: doc/mmm_engine.md
MMM_ENGINE -- requirements
Module: mmm_engine

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/modulus width in bits.
REQ-002 clk  input  1  rising-edge clock; one clock only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  clock enable; when 0 all state, including done, holds.
REQ-005 start  input  1  load-and-go strobe from the exponentiation controller, sampled when en=1.
REQ-006 clr  input  1  synchronous abort that returns the engine to IDLE, sampled when en=1.
REQ-007 a  input  WIDTH  multiplier operand A, sampled on start.
REQ-008 b  input  WIDTH  multiplicand operand B, sampled on start.
REQ-009 n  input  WIDTH  modulus N, sampled on start.
REQ-010 r  output  WIDTH  result R = A*B*2^-WIDTH mod N.
REQ-011 busy  output  1  high while a multiplication is in progress.
REQ-012 done  output  1  one-en-cycle pulse when r becomes valid.
REQ-013 n_err  output  1  set when start samples an even N; held until the next accepted start.

Function
REQ-014 The state machine SHALL have states IDLE, RUN, CORR and DONE.
REQ-015 IDLE->RUN SHALL occur on start=1 (en=1), latching a, b and n, clearing the accumulator and clearing the bit index.
REQ-016 Each RUN cycle SHALL compute acc = acc + a[i]*B, add N if the result is odd, then shift right by 1 and increment i.
REQ-017 The accumulator SHALL be WIDTH+2 bits wide, with no truncation before the shift.
REQ-018 RUN SHALL last exactly WIDTH en-cycles (i = 0..WIDTH-1, LSB first), then go to CORR.
REQ-019 CORR SHALL subtract N once if acc >= N, write the low WIDTH bits to r, and go to DONE.
REQ-020 DONE SHALL assert done for one en-cycle, then go to IDLE.
REQ-021 Latency SHALL be fixed: done=1 and r valid in the (WIDTH+2)th en-cycle after the start-sampling edge, which is 10 cycles for WIDTH=8.
REQ-022 busy SHALL be 1 in RUN and CORR, and 0 in IDLE and DONE.
REQ-023 start SHALL be ignored while busy=1; operand registers SHALL NOT change.
REQ-024 start in DONE SHALL be accepted, and done SHALL still pulse for that cycle.
REQ-025 r SHALL hold its last value until the next CORR; it SHALL NOT change on start or clr.
REQ-026 clr in any state SHALL go to IDLE, deassert busy and done, and leave r unchanged.
REQ-027 If clr and start occur together, clr SHALL win; start is dropped.
REQ-028 If N is even, n_err SHALL be set; the computation SHALL still run with the same timing, and r is undefined but deterministic.
REQ-029 A >= N or B >= N is outside the contract: no error flag is raised, and r SHALL still be < 2N, truncated to WIDTH bits.

Reset
REQ-030 While rst=1 at a rising clk edge, regardless of en, the engine SHALL go to IDLE with acc=0, i=0, r=0, busy=0, done=0 and n_err=0.
REQ-031 rst SHALL take priority over clr, start and en.
REQ-032 rst mid-RUN SHALL abort the multiplication, and no done SHALL be produced for it.

Structure
REQ-033 The shared package rsa_pkg SHALL hold WIDTH, the state enumeration and the derived constant LATENCY = WIDTH+2.
REQ-034 The block SHALL be a single module with no sub-module; the RUN step and the CORR subtractor are inline datapath.

Verification
REQ-035 WIDTH=8, N=239, A=5, B=7, start pulse -> done exactly 10 cycles later, r=227, busy high for 8+1 cycles.
REQ-036 N=239, A=17 (2^8 mod 239), B=100 -> r=100; A=0, B=200 -> r=0.
REQ-037 Second start 3 cycles after the first, with different operands -> ignored; r=227 for the first job, and only one done pulse.
REQ-038 Start with en toggling 0/1 every cycle -> done after 10 en=1 cycles, 20 clk cycles total, r=227.
REQ-039 clr asserted in cycle 4 of RUN, and separately rst asserted in cycle 4 of RUN -> busy=0 next cycle and no done; clr leaves r unchanged, rst sets r=0.
REQ-040 N=238 (even) -> n_err=1 after the start edge, done still at 10 cycles; the next start with N=239 clears n_err.
